// File: rtl/lzc_pkg.sv
// Shared types and constants for the sequential leading/trailing-zero counter.
package lzc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } lzc_state_t;

    localparam logic LZC_MODE_LEAD  = 1'b0;
    localparam logic LZC_MODE_TRAIL = 1'b1;

endpackage

// File: rtl/lzc_chunk.sv
// Combinational leading-zero count of a nonzero CHUNK-bit vector, built as a
// binary tree of 2-bit encoder cells; nz reports whether any bit was set.
module lzc_chunk #(
    parameter  int CHUNK = 4,
    localparam int LW    = $clog2(CHUNK)
) (
    input  logic [CHUNK-1:0] din,
    output logic [LW-1:0]    lz,
    output logic             nz
);

    localparam int LV = $clog2(CHUNK);

    genvar l, i;
    for (l = 0; l < LV; l++) begin : g_lvl
        localparam int N = CHUNK >> (l + 1);
        logic [l:0] c [N];
        logic       v [N];

        for (i = 0; i < N; i++) begin : g_node
            if (l == 0) begin : g_leaf
                assign v[i] = din[2*i+1] | din[2*i];
                assign c[i] = ~din[2*i+1];
            end else begin : g_merge
                // An empty upper half contributes 2^l zeros ahead of the lower half's count.
                assign v[i] = g_lvl[l-1].v[2*i+1] | g_lvl[l-1].v[2*i];
                assign c[i] = g_lvl[l-1].v[2*i+1] ? {1'b0, g_lvl[l-1].c[2*i+1]}
                                                  : {1'b1, g_lvl[l-1].c[2*i]};
            end
        end
    end

    assign lz = g_lvl[LV-1].c[0];
    assign nz = g_lvl[LV-1].v[0];

endmodule

// File: rtl/lzc_seq.sv
// Sequential leading/trailing-zero counter: scans one word CHUNK bits per cycle
// from the MSB end, stopping at the first set bit, over valid/ready handshakes.
module lzc_seq
    import lzc_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int CHUNK = 4,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_count,
    output logic             out_zero
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int LW  = $clog2(CHUNK);

    if (WIDTH < 2 || CHUNK < 2 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0 ||
        (CHUNK & (CHUNK - 1)) != 0) begin : g_bad_params
        $error("lzc_seq: illegal WIDTH=%0d / CHUNK=%0d", WIDTH, CHUNK);
    end

    lzc_state_t       state;
    logic [WIDTH-1:0] shift;
    logic [WIDTH-1:0] word_in;
    logic [CW-1:0]    acc;
    logic [IW-1:0]    idx;
    logic [CHUNK-1:0] top;
    logic [LW-1:0]    top_lz;
    logic             top_nz;

    // Trailing-zero mode reuses the MSB-first scan on the bit-reversed word.
    always_comb begin
        word_in = in_data;
        if (in_mode == LZC_MODE_TRAIL) begin
            for (int b = 0; b < WIDTH; b++) begin
                word_in[b] = in_data[WIDTH-1-b];
            end
        end
    end

    assign top = shift[WIDTH-1 -: CHUNK];

    lzc_chunk #(
        .CHUNK(CHUNK)
    ) u_chunk (
        .din(top),
        .lz (top_lz),
        .nz (top_nz)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_count <= '0;
            out_zero  <= 1'b0;
            shift     <= '0;
            acc       <= '0;
            idx       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shift    <= word_in;
                        acc      <= '0;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    if (top_nz) begin
                        out_count <= acc + CW'(top_lz);
                        out_zero  <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (idx == IW'(NCH - 1)) begin
                        out_count <= CW'(WIDTH);
                        out_zero  <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        acc   <= acc + CW'(CHUNK);
                        shift <= shift << CHUNK;
                        idx   <= idx + IW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lzc_seq.sv
// Bench for lzc_seq (WIDTH=32, CHUNK=4): bit-loop reference model checked every
// cycle, plus directed words with hand-computed counts and latencies.
module tb_lzc_seq;
    import lzc_pkg::*;

    localparam int WIDTH = 32;
    localparam int CHUNK = 4;
    localparam int CW    = 6;
    localparam int NCH   = WIDTH / CHUNK;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    out_count;
    logic             out_zero;

    lzc_seq #(
        .WIDTH(WIDTH),
        .CHUNK(CHUNK)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_mode  (in_mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_count(out_count),
        .out_zero (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: walk bits from the scan end until the first one.
    function automatic int ref_count(input logic [WIDTH-1:0] w, input logic mode);
        for (int n = 0; n < WIDTH; n++) begin
            if (mode == LZC_MODE_LEAD && w[WIDTH-1-n]) return n;
            if (mode == LZC_MODE_TRAIL && w[n]) return n;
        end
        return WIDTH;
    endfunction

    function automatic int ref_lat(input logic [WIDTH-1:0] w, input logic mode);
        int c;
        c = ref_count(w, mode);
        return (c == WIDTH) ? NCH : (c / CHUNK) + 1;
    endfunction

    // Cycle-level expectation: a busy countdown, then a held result until taken.
    bit mdl_on = 0;
    bit m_in_ready, m_valid, m_zero, p_zero;
    int m_count, p_count, m_left;

    always @(posedge clk) begin
        if (reset) begin
            m_in_ready <= 1'b1;
            m_valid    <= 1'b0;
            m_count    <= 0;
            m_zero     <= 1'b0;
            m_left     <= 0;
            mdl_on     <= 1'b1;
        end else if (m_in_ready) begin
            if (in_valid) begin
                m_in_ready <= 1'b0;
                m_left     <= ref_lat(in_data, in_mode);
                p_count    <= ref_count(in_data, in_mode);
                p_zero     <= (in_data == '0);
            end
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_valid <= 1'b1;
                m_count <= p_count;
                m_zero  <= p_zero;
            end
        end else if (m_valid && out_ready) begin
            m_valid    <= 1'b0;
            m_in_ready <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (mdl_on) begin
            check("cyc_in_ready", in_ready, m_in_ready);
            check("cyc_out_valid", out_valid, m_valid);
            check("cyc_out_count", out_count, m_count);
            check("cyc_out_zero", out_zero, m_zero);
        end
    end

    task automatic run_word(input logic [WIDTH-1:0] w, input logic mode, input int exp_cnt,
                            input bit exp_zero, input int exp_lat, input int hold,
                            input string tag);
        int cyc;
        check({tag, "_ref"}, ref_count(w, mode), exp_cnt);
        @(negedge clk);
        in_data  = w;
        in_mode  = mode;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = $urandom;
        in_mode  = ~mode;
        cyc = 0;
        do begin
            @(posedge clk);
            cyc++;
            #1;
        end while (!out_valid && cyc < 64);
        check({tag, "_latency"}, cyc, exp_lat);
        check({tag, "_count"}, out_count, exp_cnt);
        check({tag, "_zero"}, out_zero, exp_zero);
        repeat (hold) begin
            @(negedge clk);
            in_valid = 1'($urandom_range(0, 1));
            in_data  = $urandom;
            @(posedge clk);
            #1;
            check({tag, "_hold_valid"}, out_valid, 1);
            check({tag, "_hold_in_ready"}, in_ready, 0);
            check({tag, "_hold_count"}, out_count, exp_cnt);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_release_in_ready"}, in_ready, 1);
        check({tag, "_release_valid"}, out_valid, 0);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation ran past time limit, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_count", out_count, 0);
        check("reset_out_zero", out_zero, 0);
        @(negedge clk);
        reset = 1'b0;

        run_word(32'h8000_0000, LZC_MODE_LEAD,  0,  1'b0, 1, 0, "lz_msb");
        run_word(32'h0000_0001, LZC_MODE_LEAD,  31, 1'b0, 8, 0, "lz_lsb");
        run_word(32'h0000_0000, LZC_MODE_LEAD,  32, 1'b1, 8, 0, "lz_zero");
        run_word(32'h0000_0000, LZC_MODE_TRAIL, 32, 1'b1, 8, 0, "tz_zero");
        run_word(32'h0000_0100, LZC_MODE_TRAIL, 8,  1'b0, 3, 0, "tz_bit8");
        run_word(32'h8000_0000, LZC_MODE_TRAIL, 31, 1'b0, 8, 0, "tz_msb");
        run_word(32'h0001_0000, LZC_MODE_LEAD,  15, 1'b0, 4, 5, "lz_backpressure");

        // Reset during an all-zero scan drops the word.
        @(negedge clk);
        in_data  = '0;
        in_mode  = LZC_MODE_LEAD;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midscan_reset_in_ready", in_ready, 1);
        check("midscan_reset_out_valid", out_valid, 0);
        check("midscan_reset_out_count", out_count, 0);
        @(negedge clk);
        reset = 1'b0;
        run_word(32'h0F00_0000, LZC_MODE_LEAD, 4, 1'b0, 2, 0, "after_reset");

        run_word(32'h0000_0030, LZC_MODE_TRAIL, 4, 1'b0, 2, 1, "tz_mixed");
        run_word(32'h0000_8000, LZC_MODE_LEAD, 16, 1'b0, 5, 0, "lz_mid");

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
